// File: rtl/rectangle_dec_ctrl.sv
// Iterative RECTANGLE-64 decryption controller: 25 inverse rounds, SBOX_PAR shared inverse column S-boxes.
// Optional synchronous abort input is compiled in when RECT_DEC_ABORT_EN is defined.
module rectangle_dec_ctrl #(
    parameter int SBOX_PAR = 16,
    parameter int NROUNDS  = 25
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef RECT_DEC_ABORT_EN
    input  logic        abort,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ct_in,
    output logic        rk_req,
    output logic [4:0]  rk_idx,
    input  logic        rk_valid,
    input  logic [63:0] rk,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt_out
);
    localparam int N      = 16 / SBOX_PAR;
    localparam int PASS_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_ISR, S_ISB, S_DONE} fsm_t;

    fsm_t              r_fsm, w_fsm_nxt;
    logic [63:0]       r_state, w_state_nxt;
    logic [4:0]        r_round, w_round_nxt;
    logic [PASS_W-1:0] r_pass, w_pass_nxt;
    logic [63:0]       w_isr, w_isb;

    function automatic logic [3:0] sbox_dec(input logic [3:0] x);
        case (x)
            4'h0: sbox_dec = 4'h9;
            4'h1: sbox_dec = 4'h4;
            4'h2: sbox_dec = 4'hF;
            4'h3: sbox_dec = 4'hA;
            4'h4: sbox_dec = 4'hE;
            4'h5: sbox_dec = 4'h1;
            4'h6: sbox_dec = 4'h0;
            4'h7: sbox_dec = 4'h6;
            4'h8: sbox_dec = 4'hC;
            4'h9: sbox_dec = 4'h7;
            4'hA: sbox_dec = 4'h3;
            4'hB: sbox_dec = 4'h8;
            4'hC: sbox_dec = 4'h2;
            4'hD: sbox_dec = 4'hB;
            4'hE: sbox_dec = 4'h5;
            default: sbox_dec = 4'hD;
        endcase
    endfunction

    // Inverse ShiftRow: rows 1/2/3 rotate right by 1/12/13.
    assign w_isr = {r_state[60:48], r_state[63:61],
                    r_state[43:32], r_state[47:44],
                    r_state[16],    r_state[31:17],
                    r_state[15:0]};

    // One S-layer pass: columns r_pass*SBOX_PAR .. +SBOX_PAR-1; bit index is {row, column}.
    always_comb begin
        logic [3:0] v_col;
        logic [3:0] v_nib;
        // NOTE: every variable written here gets a default first so no path leaves it holding (no latch).
        v_col = '0;
        v_nib = '0;
        w_isb = r_state;
        for (int i = 0; i < SBOX_PAR; i++) begin
            v_col = 4'(int'(r_pass) * SBOX_PAR + i);
            v_nib = sbox_dec({r_state[{2'd3, v_col}], r_state[{2'd2, v_col}],
                              r_state[{2'd1, v_col}], r_state[{2'd0, v_col}]});
            w_isb[{2'd3, v_col}] = v_nib[3];
            w_isb[{2'd2, v_col}] = v_nib[2];
            w_isb[{2'd1, v_col}] = v_nib[1];
            w_isb[{2'd0, v_col}] = v_nib[0];
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_pass_nxt  = r_pass;
        case (r_fsm)
            S_IDLE: if (in_valid) begin
                w_state_nxt = ct_in;
                w_round_nxt = 5'(NROUNDS);
                w_fsm_nxt   = S_KEY;
            end
            S_KEY: if (rk_valid) begin
                w_state_nxt = r_state ^ rk;
                if (r_round == '0) begin
                    w_fsm_nxt = S_DONE;
                end else begin
                    w_round_nxt = r_round - 5'd1;
                    w_fsm_nxt   = S_ISR;
                end
            end
            S_ISR: begin
                w_state_nxt = w_isr;
                w_pass_nxt  = '0;
                w_fsm_nxt   = S_ISB;
            end
            S_ISB: begin
                w_state_nxt = w_isb;
                if (r_pass == PASS_W'(N - 1)) w_fsm_nxt = S_KEY;
                else                          w_pass_nxt = r_pass + PASS_W'(1);
            end
            S_DONE: if (out_ready) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
`ifdef RECT_DEC_ABORT_EN
        if (abort && (r_fsm != S_IDLE)) begin
            w_fsm_nxt   = S_IDLE;
            w_state_nxt = '0;
            w_round_nxt = '0;
            w_pass_nxt  = '0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_round <= '0;
            r_pass  <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign rk_req    = (r_fsm == S_KEY);
    assign rk_idx    = r_round;
    assign pt_out    = r_state;

endmodule

// File: tb/tb_rectangle_dec_ctrl.sv
// Self-checking bench: three controllers (SBOX_PAR 1, 4, 16) against a cycle-level reference model
// plus a RECTANGLE-80 encrypt/key-schedule model used to build known-answer and random vectors.
module tb_rectangle_dec_ctrl;
    localparam int NR = 25;
    localparam int ND = 3;

    typedef enum int {M_IDLE, M_KEY, M_BUSY, M_DONE} mmode_t;

    logic clk = 1'b0;
    logic rst_n;
    logic        in_valid  [ND];
    logic [63:0] ct_in     [ND];
    logic        rk_valid  [ND];
    logic        out_ready [ND];
    logic        in_ready  [ND];
    logic        rk_req    [ND];
    logic [4:0]  rk_idx    [ND];
    logic [63:0] rk        [ND];
    logic        out_valid [ND];
    logic [63:0] pt_out    [ND];
`ifdef RECT_DEC_ABORT_EN
    logic        abort     [ND];
`endif
    logic [63:0] key_tab [0:NR];

    logic [3:0] sb  [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                             4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
    logic [3:0] isb [16];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mmode_t      m_mode [ND];
    int          m_idx  [ND];
    int          m_busy [ND];
    logic [63:0] m_pt   [ND];
    logic [63:0] m_exp  [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int P = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        assign rk[g] = key_tab[rk_idx[g]];
        rectangle_dec_ctrl #(.SBOX_PAR(P), .NROUNDS(NR)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
`ifdef RECT_DEC_ABORT_EN
            .abort     (abort[g]),
`endif
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .ct_in     (ct_in[g]),
            .rk_req    (rk_req[g]),
            .rk_idx    (rk_idx[g]),
            .rk_valid  (rk_valid[g]),
            .rk        (rk[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .pt_out    (pt_out[g])
        );
    end

    function automatic int npass(input int d);
        return (d == 0) ? 16 : (d == 1) ? 4 : 1;
    endfunction

    function automatic int lat_base(input int d);
        return (d == 0) ? 451 : (d == 1) ? 151 : 76;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- cipher model ----------------
    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        logic [31:0] w;
        int m;
        w = {x, x};
        m = n % 16;
        return w[31-m -: 16];
    endfunction

    function automatic logic [63:0] sub_layer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        logic [3:0]  v;
        o = s;
        for (int j = 0; j < 16; j++) begin
            v = inv ? isb[{s[48+j], s[32+j], s[16+j], s[j]}] : sb[{s[48+j], s[32+j], s[16+j], s[j]}];
            o[48+j] = v[3];
            o[32+j] = v[2];
            o[16+j] = v[1];
            o[j]    = v[0];
        end
        return o;
    endfunction

    function automatic logic [63:0] shift_layer(input logic [63:0] s, input bit inv);
        int amt [4] = '{0, 1, 12, 13};
        logic [63:0] o;
        for (int i = 0; i < 4; i++)
            o[16*i +: 16] = rotl16(s[16*i +: 16], inv ? (16 - amt[i]) : amt[i]);
        return o;
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [63:0] s;
        s = pt;
        for (int r = 0; r < NR; r++) s = shift_layer(sub_layer(s ^ key_tab[r], 1'b0), 1'b0);
        return s ^ key_tab[NR];
    endfunction

    function automatic logic [63:0] decrypt(input logic [63:0] ct);
        logic [63:0] s;
        s = ct ^ key_tab[NR];
        for (int r = NR - 1; r >= 0; r--) s = sub_layer(shift_layer(s, 1'b1), 1'b1) ^ key_tab[r];
        return s;
    endfunction

    task automatic gen_keys(input logic [79:0] key);
        logic [15:0] r [5];
        logic [15:0] t [5];
        logic [3:0]  v;
        logic [4:0]  rc;
        rc = 5'h01;
        for (int i = 0; i < 5; i++) r[i] = key[16*i +: 16];
        for (int k = 0; k <= NR; k++) begin
            key_tab[k] = {r[3], r[2], r[1], r[0]};
            for (int j = 0; j < 4; j++) begin
                v = sb[{r[3][j], r[2][j], r[1][j], r[0][j]}];
                r[3][j] = v[3]; r[2][j] = v[2]; r[1][j] = v[1]; r[0][j] = v[0];
            end
            t[0] = rotl16(r[0], 8) ^ r[1];
            t[1] = r[2];
            t[2] = r[3];
            t[3] = rotl16(r[3], 12) ^ r[4];
            t[4] = r[0];
            for (int i = 0; i < 5; i++) r[i] = t[i];
            r[0][4:0] = r[0][4:0] ^ rc;
            rc = {rc[3:0], rc[4] ^ rc[2]};
        end
    endtask

    initial for (int v = 0; v < 16; v++) isb[sb[v]] = 4'(v);

    // ---------------- cycle-level reference model ----------------
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                m_mode[d] = M_IDLE;
                m_idx[d]  = 0;
                m_pt[d]   = '0;
`ifdef RECT_DEC_ABORT_EN
            end else if (abort[d] && m_mode[d] != M_IDLE) begin
                m_mode[d] = M_IDLE;
                m_idx[d]  = 0;
                m_pt[d]   = '0;
`endif
            end else begin
                case (m_mode[d])
                    M_IDLE: if (in_valid[d]) begin
                        m_mode[d] = M_KEY;
                        m_idx[d]  = NR;
                        m_exp[d]  = decrypt(ct_in[d]);
                    end
                    M_KEY: if (rk_valid[d]) begin
                        if (m_idx[d] == 0) begin
                            m_mode[d] = M_DONE;
                            m_pt[d]   = m_exp[d];
                        end else begin
                            m_idx[d]--;
                            m_mode[d] = M_BUSY;
                            m_busy[d] = npass(d) + 1;
                        end
                    end
                    M_BUSY: begin
                        m_busy[d]--;
                        if (m_busy[d] == 0) m_mode[d] = M_KEY;
                    end
                    default: if (out_ready[d]) m_mode[d] = M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                check($sformatf("d%0d in_ready", d),  64'(in_ready[d]),  64'(m_mode[d] == M_IDLE));
                check($sformatf("d%0d out_valid", d), 64'(out_valid[d]), 64'(m_mode[d] == M_DONE));
                check($sformatf("d%0d rk_req", d),    64'(rk_req[d]),    64'(m_mode[d] == M_KEY));
                if (m_mode[d] == M_KEY)
                    check($sformatf("d%0d rk_idx", d), 64'(rk_idx[d]), 64'(m_idx[d]));
                if (m_mode[d] == M_IDLE || m_mode[d] == M_DONE)
                    check($sformatf("d%0d pt_out", d), pt_out[d], m_pt[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int d, input logic [63:0] ct, input logic [63:0] exp_pt,
                             input int stall_idx, input int stall_len, input int bp, input bit rnd);
        int cyc;
        int left;
        int extra;
        ct_in[d]     = ct;
        in_valid[d]  = 1'b1;
        rk_valid[d]  = 1'b1;
        out_ready[d] = (bp == 0);
        tick();
        in_valid[d] = 1'b0;
        cyc = 0;
        left = stall_len;
        extra = 0;
        while (!out_valid[d] && cyc < 2000) begin
            if (rnd) rk_valid[d] = ($urandom_range(0, 3) != 0);
            else if (rk_req[d] && int'(rk_idx[d]) == stall_idx && left > 0) begin
                rk_valid[d] = 1'b0;
                left--;
            end else rk_valid[d] = 1'b1;
            if (rk_req[d] && !rk_valid[d]) extra++;
            tick();
            cyc++;
        end
        rk_valid[d] = 1'b1;
        check($sformatf("d%0d latency", d), 64'(cyc), 64'(lat_base(d) + extra));
        if (stall_len > 0) check($sformatf("d%0d stall applied", d), 64'(left), 64'd0);
        check($sformatf("d%0d plaintext", d), pt_out[d], exp_pt);
        if (bp > 0) begin
            in_valid[d] = 1'b1;
            ct_in[d] = {$urandom, $urandom};
            repeat (bp) begin
                tick();
                check($sformatf("d%0d bp out_valid", d), 64'(out_valid[d]), 64'd1);
                check($sformatf("d%0d bp in_ready", d),  64'(in_ready[d]),  64'd0);
                check($sformatf("d%0d bp pt_out", d),    pt_out[d], exp_pt);
            end
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        tick();
        check($sformatf("d%0d post in_ready", d),  64'(in_ready[d]),  64'd1);
        check($sformatf("d%0d post out_valid", d), 64'(out_valid[d]), 64'd0);
        check($sformatf("d%0d post pt_out", d),    pt_out[d], exp_pt);
    endtask

    task automatic reset_checks(input string tag, input int d);
        check($sformatf("%s d%0d in_ready", tag, d),  64'(in_ready[d]),  64'd1);
        check($sformatf("%s d%0d out_valid", tag, d), 64'(out_valid[d]), 64'd0);
        check($sformatf("%s d%0d rk_req", tag, d),    64'(rk_req[d]),    64'd0);
        check($sformatf("%s d%0d rk_idx", tag, d),    64'(rk_idx[d]),    64'd0);
        check($sformatf("%s d%0d pt_out", tag, d),    pt_out[d],         64'h0);
    endtask

    task automatic wait_idx(input int d, input int idx);
        int cyc;
        cyc = 0;
        while (!(rk_req[d] && int'(rk_idx[d]) == idx) && cyc < 1000) begin
            tick();
            cyc++;
        end
        check($sformatf("d%0d reach rk_idx", d), 64'(rk_idx[d]), 64'(idx));
    endtask

    initial begin
        logic [63:0] pt;
        logic [63:0] kat_pt [2];
        logic [79:0] kat_key [2];
        kat_pt[0]  = 64'h0;
        kat_pt[1]  = 64'hFFFF_FFFF_FFFF_FFFF;
        kat_key[0] = 80'h0;
        kat_key[1] = {80{1'b1}};
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            ct_in[d]     = '0;
            rk_valid[d]  = 1'b1;
            out_ready[d] = 1'b1;
`ifdef RECT_DEC_ABORT_EN
            abort[d]     = 1'b0;
`endif
        end
        rst_n = 1'b0;
        gen_keys(80'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int d = 0; d < ND; d++) reset_checks("reset", d);

        // Known answer: encrypt with the model, decrypt on every datapath width.
        for (int k = 0; k < 2; k++) begin
            gen_keys(kat_key[k]);
            for (int p = 0; p < 2; p++)
                for (int d = 0; d < ND; d++)
                    run_block(d, encrypt(kat_pt[p]), kat_pt[p], -1, 0, 0, 1'b0);
        end

        // Key-index sequence and latency with a recognisable ciphertext.
        gen_keys(80'h0123_4567_89AB_CDEF_0F1E);
        run_block(2, 64'h0123_4567_89AB_CDEF, decrypt(64'h0123_4567_89AB_CDEF), -1, 0, 0, 1'b0);
        run_block(1, 64'h0123_4567_89AB_CDEF, decrypt(64'h0123_4567_89AB_CDEF), -1, 0, 0, 1'b0);

        // Key stall at index 10, then output backpressure with a pending block.
        pt = 64'hDEAD_BEEF_0BAD_F00D;
        run_block(1, encrypt(pt), pt, 10, 5, 0, 1'b0);
        run_block(1, encrypt(pt), pt, -1, 0, 3, 1'b0);

        // Reset mid-ISB discards the in-flight block.
        ct_in[1] = 64'h1111_2222_3333_4444;
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        wait_idx(1, 20);
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        reset_checks("midreset", 1);
        tick();
        reset_checks("midreset+1", 1);

`ifdef RECT_DEC_ABORT_EN
        // Abort in round 12, ISB pass 2, then a clean block.
        ct_in[1] = 64'h5555_AAAA_5555_AAAA;
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        wait_idx(1, 13);
        repeat (4) tick();
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        reset_checks("abort", 1);
        pt = 64'h0F0F_1234_8765_F0F0;
        run_block(1, encrypt(pt), pt, -1, 0, 0, 1'b0);
`endif

        // Randomised blocks: random keys, plaintexts, key stalls and backpressure.
        for (int n = 0; n < 24; n++) begin
            int d;
            d = (n < 18) ? 1 : (n < 22) ? 2 : 0;
            gen_keys({$urandom, $urandom, 16'($urandom)});
            pt = {$urandom, $urandom};
            run_block(d, encrypt(pt), pt, -1, 0, int'($urandom_range(0, 3)), 1'b1);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rectangle_dec_ctrl.md
Name: rectangle_dec_ctrl

Overview:
- Iterative RECTANGLE-64 decryption controller: sequences 25 inverse rounds over a 64-bit state register.
- Shares SBOX_PAR instances of the inverse 4-bit column S-box (sbox_dec) across the 16 columns.
- Round keys come from an external key-schedule/key-store block through a request/valid interface.
- Sits between the block-level ciphertext input handshake and the plaintext output handshake.

Parameters:
- SBOX_PAR, 16, number of sbox_dec instances. Legal values: 1, 2, 4, 8, 16. Passes per S-layer N = 16/SBOX_PAR.
- NROUNDS, 25, number of inverse rounds. Round keys indexed 0..NROUNDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  ciphertext present.
- in_ready  output  1  controller idle; ciphertext accepted on in_valid&in_ready.
- ct_in  input  64  ciphertext. Row r is bits [16r+15:16r].
- rk_req  output  1  round key requested.
- rk_idx  output  5  index of requested round key.
- rk_valid  input  1  rk valid for current rk_idx.
- rk  input  64  round key.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts plaintext.
- pt_out  output  64  plaintext; equals the state register.

Behaviour:
- Reset: rst_n low at a clock edge gives state=0, FSM=IDLE, round=0, pass=0. Outputs after reset: in_ready=1, out_valid=0, rk_req=0, rk_idx=0, pt_out=0. Reset takes effect mid-operation too; any in-flight block is discarded.
- FSM states: IDLE, KEY, ISR, ISB, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state<=ct_in, round<=NROUNDS, go to KEY.
- KEY:
  - rk_req=1, rk_idx=round.
  - Holds while rk_valid=0.
  - On rk_valid: state<=state^rk. If round==0 go to DONE; else round<=round-1 and go to ISR.
- ISR (1 cycle): inverse ShiftRow.
  - row0 unchanged.
  - row1 rotated right by 1.
  - row2 rotated right by 12.
  - row3 rotated right by 13.
  - Then go to ISB with pass=0.
- ISB (N cycles):
  - Pass k substitutes columns k*SBOX_PAR .. k*SBOX_PAR+SBOX_PAR-1.
  - Column j nibble = {row3[j],row2[j],row1[j],row0[j]}, MSB = row3. The result is written back to the same bit positions.
  - Other columns are untouched.
  - After pass N-1 go to KEY.
- DONE:
  - out_valid=1 and pt_out=state; both hold stable until out_ready.
  - On out_ready go to IDLE. State is retained, so pt_out keeps the last plaintext.
- in_ready=1 only in IDLE. in_valid in any other state is ignored.
- Key order: rk_idx takes NROUNDS, NROUNDS-1, …, 0. Each index is requested exactly once per block. rk_idx is stable while rk_req=1.
- Latency: with rk_valid tied high and out_ready high, out_valid first rises 1+NROUNDS*(N+2) cycles after the accept edge. For SBOX_PAR=16 that is 76; for 4 it is 151; for 1 it is 451. Each cycle of rk_valid low adds one cycle.
- out_valid and out_ready together in DONE: handshake completes, and in_ready=1 in the next cycle. No bypass from DONE to a new block in the same cycle.

Optional Feature:
- Macro: RECT_DEC_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in any non-IDLE state forces IDLE, state<=0, round<=0, pass<=0.
  - Next cycle: rk_req=0, out_valid=0, in_ready=1.
  - abort in IDLE is ignored, and it takes priority over in_valid.
  - rst_n has priority over abort.
- Not defined: port absent and no abort logic.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles mid-ISB, then release -> in_ready=1, out_valid=0, rk_req=0, pt_out=0x0000000000000000.
- Key sequence and latency: SBOX_PAR=16, rk_valid=1, ct_in=0x0123456789ABCDEF -> rk_idx observed 25 down to 0, each once; out_valid at cycle 76. Same test with SBOX_PAR=4 -> out_valid at cycle 151.
- Known answer: encrypt 0x0000000000000000 and 0xFFFFFFFFFFFFFFFF with the golden model under the 80-bit zero key and the 80-bit all-ones key. Supply the model's round keys, decrypt -> pt_out equals the original plaintexts exactly, for SBOX_PAR 1, 4 and 16.
- Key stall: hold rk_valid=0 for 5 cycles when rk_idx=10 -> rk_idx stays 10, total latency +5, plaintext unchanged.
- Output backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 -> out_valid and pt_out stable, in_ready=0, no new block accepted. After out_ready, in_ready=1 the next cycle.
- Abort (RECT_DEC_ABORT_EN defined): abort=1 during round 12 ISB pass 2 -> next cycle in_ready=1, rk_req=0, pt_out=0. A following block decrypts correctly.
